ucode_ctrl_store: RTL and testbench
===================================

Name: ucode_ctrl_store

Overview:
- Writable, parametrised successor to the fixed decode ROM.
- Maps a decode address (opcode/funct bits) to a control word, with a registered valid/ready lookup pipe.
- Has a runtime programming port and a per-entry valid bit; unprogrammed addresses are flagged illegal.
- Has a hardware init/flush sweep and a saturating illegal-hit counter.
- Sits between the decode-address formation logic and the execute-stage control decode.

Parameters:
- ADDR_W, 11, decode address width; depth = 2**ADDR_W entries.
- CTRL_W, 17, control word width.
- DEFAULT_WORD, {CTRL_W{1'b0}}, word driven on cs_ctrl for unprogrammed entries.
- CNT_W, 16, illegal-hit counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  one-cycle pulse; invalidates all entries via a sweep.
- busy  out  1  high while the init/flush sweep runs.
- lk_valid  in  1  lookup request valid.
- lk_ready  out  1  lookup request accepted when lk_valid&lk_ready.
- lk_addr  in  ADDR_W  lookup address.
- cs_valid  out  1  result valid.
- cs_ready  in  1  downstream accepts result.
- cs_ctrl  out  CTRL_W  control word.
- cs_illegal  out  1  entry was unprogrammed.
- pg_valid  in  1  program request valid.
- pg_ready  out  1  program request accepted.
- pg_addr  in  ADDR_W  program address.
- pg_data  in  CTRL_W  program data.
- pg_inval  in  1  1 = clear this entry's valid bit instead of writing it.
- illegal_cnt  out  CNT_W  saturating count of illegal results consumed.

Behaviour:
- Reset values (async): state=INIT, sweep counter=0, busy=1, cs_valid=0, cs_ctrl=DEFAULT_WORD, cs_illegal=0, illegal_cnt=0.
- lk_ready and pg_ready are 0 during reset. Word storage is not reset.
- FSM states are INIT and RUN.
  - INIT: clear valid[sweep] each cycle and increment the counter.
  - INIT exits to RUN the cycle after clearing entry 2**ADDR_W-1, i.e. 2**ADDR_W cycles in INIT.
  - RUN: on flush=1, go to INIT with counter=0 and drop cs_valid. Requests presented that cycle are not accepted.
  - flush during INIT restarts the counter at 0.
  - Assertion of rst mid-sweep restarts the sweep.
- busy = (state==INIT).
- Handshakes:
  - pg_ready = (state==RUN) && !flush.
  - lk_ready = (state==RUN) && !flush && (!cs_valid || cs_ready).
- Lookup latency is 1 cycle: accepted at edge N, result is valid after edge N. No combinational path from lk_addr to cs_ctrl.
- Result:
  - cs_ctrl = valid[a] ? word[a] : DEFAULT_WORD.
  - cs_illegal = !valid[a].
  - cs_valid and its data hold stable while cs_valid && !cs_ready.
  - cs_valid clears when consumed without a new accept.
  - Back-to-back accepts give full throughput.
- Program write: on pg_valid&&pg_ready,
  - pg_inval=0: word[pg_addr] <= pg_data, valid[pg_addr] <= 1.
  - pg_inval=1: valid[pg_addr] <= 0 and the word is untouched.
- Simultaneous program and lookup to the same address in one cycle: the lookup returns the new value (write-first bypass). For invalidate, the lookup returns DEFAULT_WORD with illegal=1.
- illegal_cnt increments on cs_valid&&cs_ready&&cs_illegal and saturates at all-ones. It is not cleared by flush.

Decomposition:
- Shared package ucode_pkg holds:
  - ADDR_W/CTRL_W defaults.
  - Control-word field offsets (alu_op, src select, branch type, wb enable).
  - The state enum ST_INIT/ST_RUN.
  - The DEFAULT_WORD constant.
- One sub-module, ucode_store_ram: simple-dual-port storage (1 write, 1 registered read, CTRL_W+1 wide incl. valid).
  - Invalidation writes valid=0 with data don't-care.
  - The bypass mux lives in the top.

Test Plan:
- Reset release → busy=1 for exactly 2048 cycles, lk_ready=0 throughout. Then a lookup at 11'b01101110000 returns cs_illegal=1, cs_ctrl=17'h0, illegal_cnt=1.
- Program 11'b01101110000 ← 17'b11010100000000001, then look it up → one cycle later cs_valid=1, cs_ctrl=17'b11010100000000001, cs_illegal=0.
- Same-cycle program 11'b11000110000 ← 17'b00011010000000000 and lookup of the same address → result equals the new word with illegal=0. Repeat with pg_inval=1 → DEFAULT_WORD with illegal=1.
- Hold cs_ready=0 for 5 cycles with lk_valid=1 → lk_ready=0 and cs_ctrl stable. Then stream 4 back-to-back lookups with cs_ready=1 → 4 results on 4 consecutive cycles, in order.
- Program 3 entries, then pulse flush → busy for 2048 cycles, after which all 3 lookups return illegal. illegal_cnt continues from its prior value.
- Force 2**CNT_W+3 illegal consumes (CNT_W=4 build) → illegal_cnt stops at 4'hF. Assert rst mid-sweep at cycle 100 → outputs return to reset values immediately and the sweep restarts from 0.

Source files
------------

// File: rtl/ucode_pkg.sv
// Shared definitions for the writable microcode control store:
// default widths, control-word field layout, FSM state codes.
package ucode_pkg;

    localparam int unsigned UCODE_ADDR_W = 11;
    localparam int unsigned UCODE_CTRL_W = 17;

    localparam int unsigned ALU_OP_LSB  = 0;
    localparam int unsigned ALU_OP_W    = 5;
    localparam int unsigned SRC_SEL_LSB = 5;
    localparam int unsigned SRC_SEL_W   = 4;
    localparam int unsigned BR_TYPE_LSB = 9;
    localparam int unsigned BR_TYPE_W   = 3;
    localparam int unsigned WB_EN_BIT   = 16;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [UCODE_CTRL_W-1:0] UCODE_DEFAULT_WORD = '0;

    // Bits 15:12 are reserved for future execute-stage controls.
    typedef struct packed {
        logic       wb_en;
        logic [3:0] rsvd;
        logic [2:0] br_type;
        logic [3:0] src_sel;
        logic [4:0] alu_op;
    } ucode_ctrl_t;

endpackage

// File: rtl/ucode_store_ram.sv
// Simple dual-port storage for {valid, word}: one write port and one
// registered read port that only updates when a read is enabled.
module ucode_store_ram #(
    parameter int unsigned       ADDR_W = 11,
    parameter int unsigned       DATA_W = 18,
    parameter logic [DATA_W-1:0] RD_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_q, rd_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read-before-write: same-address collisions are resolved by the caller.
    always_comb begin
        rd_d = rd_q;
        if (re) begin
            rd_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= RD_RST;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/ucode_ctrl_store.sv
// Writable decode control store: registered lookup pipe, runtime programming
// port, init/flush valid-bit sweep and a saturating illegal-hit counter.
module ucode_ctrl_store
    import ucode_pkg::*;
#(
    parameter int unsigned       ADDR_W       = UCODE_ADDR_W,
    parameter int unsigned       CTRL_W       = UCODE_CTRL_W,
    parameter logic [CTRL_W-1:0] DEFAULT_WORD = {CTRL_W{1'b0}},
    parameter int unsigned       CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    output logic              busy,
    input  logic              lk_valid,
    output logic              lk_ready,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              cs_valid,
    input  logic              cs_ready,
    output logic [CTRL_W-1:0] cs_ctrl,
    output logic              cs_illegal,
    input  logic              pg_valid,
    output logic              pg_ready,
    input  logic [ADDR_W-1:0] pg_addr,
    input  logic [CTRL_W-1:0] pg_data,
    input  logic              pg_inval,
    output logic [CNT_W-1:0]  illegal_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              cs_valid_q, cs_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              byp_q, byp_d;
    logic              byp_inval_q, byp_inval_d;
    logic [CTRL_W-1:0] byp_data_q, byp_data_d;

    logic              run, pg_fire, lk_fire, consume;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [CTRL_W:0]   ram_wdata, ram_rdata;
    logic              hit_valid;
    logic [CTRL_W-1:0] hit_word;

    always_comb begin
        run      = (state_q == ST_RUN);
        pg_ready = run && !flush;
        lk_ready = run && !flush && (!cs_valid_q || cs_ready);
        pg_fire  = pg_valid && pg_ready;
        lk_fire  = lk_valid && lk_ready;
        consume  = cs_valid_q && cs_ready;
    end

    // The sweep owns the write port in INIT; programming owns it in RUN.
    always_comb begin
        ram_we    = pg_fire;
        ram_waddr = pg_addr;
        ram_wdata = {!pg_inval, pg_data};
        if (!run) begin
            ram_we    = 1'b1;
            ram_waddr = sweep_q;
            ram_wdata = {1'b0, DEFAULT_WORD};
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        cs_valid_d  = cs_valid_q;
        cnt_d       = cnt_q;
        byp_d       = byp_q;
        byp_inval_d = byp_inval_q;
        byp_data_d  = byp_data_q;

        if (lk_fire) begin
            cs_valid_d  = 1'b1;
            byp_d       = pg_fire && (pg_addr == lk_addr);
            byp_inval_d = pg_inval;
            byp_data_d  = pg_data;
        end else if (consume) begin
            cs_valid_d = 1'b0;
        end

        if (consume && cs_illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (flush) begin
            state_d    = ST_INIT;
            sweep_d    = '0;
            cs_valid_d = 1'b0;
        end else if (!run) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            cs_valid_q  <= 1'b0;
            cnt_q       <= '0;
            byp_q       <= 1'b0;
            byp_inval_q <= 1'b0;
            byp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            cs_valid_q  <= cs_valid_d;
            cnt_q       <= cnt_d;
            byp_q       <= byp_d;
            byp_inval_q <= byp_inval_d;
            byp_data_q  <= byp_data_d;
        end
    end

    // Read register resets to a "valid default" entry so that the reset
    // outputs are cs_ctrl=DEFAULT_WORD with cs_illegal=0.
    ucode_store_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (CTRL_W + 1),
        .RD_RST ({1'b1, DEFAULT_WORD})
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .re      (lk_fire),
        .raddr   (lk_addr),
        .rd_data (ram_rdata)
    );

    // Write-first bypass for a program hitting the address looked up that cycle.
    always_comb begin
        hit_valid   = byp_q ? !byp_inval_q : ram_rdata[CTRL_W];
        hit_word    = byp_q ? byp_data_q : ram_rdata[CTRL_W-1:0];
        cs_ctrl     = hit_valid ? hit_word : DEFAULT_WORD;
        cs_illegal  = !hit_valid;
        cs_valid    = cs_valid_q;
        busy        = (state_q == ST_INIT);
        illegal_cnt = cnt_q;
    end

endmodule

// File: tb/tb_ucode_ctrl_store.sv
// Directed plus randomized bench for ucode_ctrl_store (CNT_W=4 build) checked
// against a table-level model of entries, result slot and illegal counter.
module tb_ucode_ctrl_store;

    localparam int unsigned AW    = 11;
    localparam int unsigned CW    = 17;
    localparam int unsigned NW    = 4;
    localparam int unsigned DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst, flush, lk_valid, cs_ready, pg_valid, pg_inval;
    logic [AW-1:0] lk_addr, pg_addr;
    logic [CW-1:0] pg_data;
    logic          busy, lk_ready, cs_valid, cs_illegal, pg_ready;
    logic [CW-1:0] cs_ctrl;
    logic [NW-1:0] illegal_cnt;

    int total = 0;
    int bad   = 0;

    bit            m_vld  [DEPTH];
    logic [CW-1:0] m_word [DEPTH];
    bit            m_busy;
    int            m_init_left;
    bit            m_cs_valid;
    logic [CW-1:0] m_cs_ctrl;
    bit            m_cs_illegal;
    int            m_cnt;

    logic [AW-1:0] sa [4];
    logic [CW-1:0] sd [4];
    int            pre_cnt;

    ucode_ctrl_store #(
        .ADDR_W (AW),
        .CTRL_W (CW),
        .CNT_W  (NW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .busy        (busy),
        .lk_valid    (lk_valid),
        .lk_ready    (lk_ready),
        .lk_addr     (lk_addr),
        .cs_valid    (cs_valid),
        .cs_ready    (cs_ready),
        .cs_ctrl     (cs_ctrl),
        .cs_illegal  (cs_illegal),
        .pg_valid    (pg_valid),
        .pg_ready    (pg_ready),
        .pg_addr     (pg_addr),
        .pg_data     (pg_data),
        .pg_inval    (pg_inval),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush    = 1'b0;
        lk_valid = 1'b0;
        lk_addr  = '0;
        cs_ready = 1'b1;
        pg_valid = 1'b0;
        pg_addr  = '0;
        pg_data  = '0;
        pg_inval = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        m_busy       = 1'b1;
        m_init_left  = DEPTH;
        m_cs_valid   = 1'b0;
        m_cs_ctrl    = '0;
        m_cs_illegal = 1'b0;
        m_cnt        = 0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_busy"}, 32'(busy), 32'd1);
        check({pfx, "_cs_valid"}, 32'(cs_valid), 32'd0);
        check({pfx, "_cs_ctrl"}, 32'(cs_ctrl), 32'd0);
        check({pfx, "_cs_illegal"}, 32'(cs_illegal), 32'd0);
        check({pfx, "_illegal_cnt"}, 32'(illegal_cnt), 32'd0);
        check({pfx, "_lk_ready"}, 32'(lk_ready), 32'd0);
        check({pfx, "_pg_ready"}, 32'(pg_ready), 32'd0);
    endtask

    // Called at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic cycle();
        bit e_pg_rdy, e_lk_rdy, pg_fire, lk_fire, consume;
        #1;
        e_pg_rdy = !m_busy && !flush;
        e_lk_rdy = e_pg_rdy && (!m_cs_valid || cs_ready);
        check("pg_ready", 32'(pg_ready), 32'(e_pg_rdy));
        check("lk_ready", 32'(lk_ready), 32'(e_lk_rdy));
        pg_fire = pg_valid && e_pg_rdy;
        lk_fire = lk_valid && e_lk_rdy;
        consume = m_cs_valid && cs_ready;
        @(posedge clk);
        if (consume && m_cs_illegal && m_cnt < (2 ** NW) - 1) m_cnt++;
        if (pg_fire) begin
            if (pg_inval) m_vld[pg_addr] = 1'b0;
            else begin
                m_vld[pg_addr]  = 1'b1;
                m_word[pg_addr] = pg_data;
            end
        end
        if (lk_fire) begin
            m_cs_valid   = 1'b1;
            m_cs_illegal = !m_vld[lk_addr];
            m_cs_ctrl    = m_vld[lk_addr] ? m_word[lk_addr] : '0;
        end else if (consume) begin
            m_cs_valid = 1'b0;
        end
        if (flush) begin
            m_cs_valid  = 1'b0;
            m_busy      = 1'b1;
            m_init_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        end else if (m_busy) begin
            m_init_left--;
            if (m_init_left == 0) m_busy = 1'b0;
        end
        #1;
        check("busy", 32'(busy), 32'(m_busy));
        check("cs_valid", 32'(cs_valid), 32'(m_cs_valid));
        check("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
        if (m_cs_valid) begin
            check("cs_ctrl", 32'(cs_ctrl), 32'(m_cs_ctrl));
            check("cs_illegal", 32'(cs_illegal), 32'(m_cs_illegal));
        end
    endtask

    task automatic wait_sweep(input string tag);
        for (int i = 0; i < DEPTH + 16 && m_busy; i++) cycle();
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        model_reset();
        rst = 1'b0;

        // Lookup held during the sweep must not be accepted until RUN.
        lk_valid = 1'b1;
        lk_addr  = 11'b01101110000;
        wait_sweep("init_done");
        cycle();
        check("first_illegal", 32'(cs_illegal), 32'd1);
        check("first_ctrl", 32'(cs_ctrl), 32'h0);
        lk_valid = 1'b0;
        cycle();
        check("first_cnt", 32'(illegal_cnt), 32'd1);

        pg_valid = 1'b1;
        pg_addr  = 11'b01101110000;
        pg_data  = 17'b11010100000000001;
        cycle();
        idle();
        lk_valid = 1'b1;
        lk_addr  = 11'b01101110000;
        cycle();
        check("prog_valid", 32'(cs_valid), 32'd1);
        check("prog_ctrl", 32'(cs_ctrl), 32'(17'b11010100000000001));
        check("prog_illegal", 32'(cs_illegal), 32'd0);
        idle();
        cycle();

        // Same-cycle program and lookup: write-first.
        pg_valid = 1'b1;
        pg_addr  = 11'b11000110000;
        pg_data  = 17'b00011010000000000;
        lk_valid = 1'b1;
        lk_addr  = 11'b11000110000;
        cycle();
        check("byp_ctrl", 32'(cs_ctrl), 32'(17'b00011010000000000));
        check("byp_illegal", 32'(cs_illegal), 32'd0);
        pg_inval = 1'b1;
        pg_data  = 17'h1ffff;
        cycle();
        check("byp_inv_ctrl", 32'(cs_ctrl), 32'h0);
        check("byp_inv_illegal", 32'(cs_illegal), 32'd1);
        idle();
        cycle();

        // Stall then stream.
        for (int i = 0; i < 4; i++) begin
            sa[i]    = 11'(16 + i);
            sd[i]    = 17'($urandom);
            pg_valid = 1'b1;
            pg_addr  = sa[i];
            pg_data  = sd[i];
            cycle();
        end
        idle();
        lk_valid = 1'b1;
        lk_addr  = sa[0];
        cs_ready = 1'b0;
        cycle();
        lk_addr = sa[1];
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_ctrl", 32'(cs_ctrl), 32'(sd[0]));
        end
        cs_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lk_addr = sa[i];
            cycle();
            check("stream_valid", 32'(cs_valid), 32'd1);
            check("stream_ctrl", 32'(cs_ctrl), 32'(sd[i]));
        end
        idle();
        cycle();

        // Program three, flush, then all three must read illegal.
        for (int i = 0; i < 3; i++) begin
            pg_valid = 1'b1;
            pg_addr  = 11'(32 + i);
            pg_data  = 17'($urandom);
            cycle();
        end
        idle();
        pre_cnt  = m_cnt;
        flush    = 1'b1;
        lk_valid = 1'b1;
        lk_addr  = 11'd32;
        pg_valid = 1'b1;
        pg_addr  = 11'd33;
        cycle();
        idle();
        wait_sweep("flush_done");
        for (int i = 0; i < 3; i++) begin
            lk_valid = 1'b1;
            lk_addr  = 11'(32 + i);
            cycle();
            check("flush_illegal", 32'(cs_illegal), 32'd1);
        end
        idle();
        cycle();
        check("cnt_continues", 32'(illegal_cnt), 32'(pre_cnt + 3));

        for (int i = 0; i < 300; i++) begin
            lk_valid = 1'($urandom_range(0, 1));
            lk_addr  = 11'(256 + $urandom_range(0, 7));
            pg_valid = 1'($urandom_range(0, 1));
            pg_addr  = 11'(256 + $urandom_range(0, 7));
            pg_data  = 17'($urandom);
            pg_inval = ($urandom_range(0, 3) == 0);
            cs_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle();
        cycle();

        // Saturation: 2**NW+3 illegal consumes.
        lk_valid = 1'b1;
        lk_addr  = 11'h7ff;
        for (int i = 0; i < (2 ** NW) + 3; i++) cycle();
        idle();
        cycle();
        check("cnt_saturated", 32'(illegal_cnt), 32'hf);

        // Reset asserted 100 cycles into a sweep.
        flush = 1'b1;
        cycle();
        idle();
        for (int i = 0; i < 99; i++) cycle();
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_sweep("restart_done");
        lk_valid = 1'b1;
        lk_addr  = 11'b01101110000;
        cycle();
        check("post_rst_illegal", 32'(cs_illegal), 32'd1);
        idle();
        cycle();
        check("post_rst_cnt", 32'(illegal_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
